// File: rtl/cmos_capture_window.sv
// CMOS sensor capture front end: frame gating, byte-to-pixel packing,
// crop window, coordinates, frame counting and line-integrity checks.
module cmos_capture_window #(
   parameter int DATA_W     = 8,
   parameter int BPP        = 2,
   parameter int WAIT_FRAME = 10,
   parameter int CNT_W      = 12,
   parameter int MSB_FIRST  = 1
) (
   input  logic                    cam_pclk,
   input  logic                    rst,
   input  logic                    cam_vsync,
   input  logic                    cam_href,
   input  logic [DATA_W-1:0]       cam_data,
   input  logic                    cap_en,
   input  logic [CNT_W-1:0]        win_x0,
   input  logic [CNT_W-1:0]        win_x1,
   input  logic [CNT_W-1:0]        win_y0,
   input  logic [CNT_W-1:0]        win_y1,
   output logic                    cmos_frame_vsync,
   output logic                    cmos_frame_href,
   output logic                    cmos_frame_valid,
   output logic [DATA_W*BPP-1:0]   cmos_frame_data,
   output logic [CNT_W-1:0]        pix_x,
   output logic [CNT_W-1:0]        pix_y,
   output logic [15:0]             frame_cnt,
   output logic                    frame_done,
   output logic                    line_err
);

   localparam int PW = DATA_W * BPP;
   localparam int BW = (BPP > 1) ? $clog2(BPP) : 1;
   localparam int WW = $clog2(WAIT_FRAME + 2);
   localparam logic [BW-1:0] LAST = BW'(BPP - 1);

   typedef enum logic [1:0] {S_WAIT, S_ARMED, S_ACTIVE} state_t;
   state_t state, state_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [PW-1:0] pack(input logic [PW-1:0] acc,
                                          input logic [DATA_W-1:0] b);
      logic [PW-1:0] bz;
      bz = PW'(b);
      if (MSB_FIRST != 0) return (acc << DATA_W) | bz;
      else                return (acc >> DATA_W) | (bz << (PW - DATA_W));
   endfunction

   // ---- stage p0: input registers ----
   logic              vsync_p0, href_p0;
   logic [DATA_W-1:0] data_p0;

   always_ff @(posedge cam_pclk) begin
      if (rst) begin
         vsync_p0 <= 1'b0;
         href_p0  <= 1'b0;
      end else begin
         vsync_p0 <= cam_vsync;
         href_p0  <= cam_href;
      end
   end

   always_ff @(posedge cam_pclk) data_p0 <= cam_data;

   // ---- stage p1: framing, packing, coordinates, window test ----
   logic              vsync_p1, href_p1;
   logic [BW-1:0]     byte_cnt;
   logic [CNT_W-1:0]  x_cnt, y_cnt, ref_cnt;
   logic              line_bad;
   logic [WW-1:0]     wait_cnt;
   logic [CNT_W-1:0]  wx0, wx1, wy0, wy1;
   logic [PW-1:0]     acc, data_p1;
   logic [CNT_W-1:0]  x_p1, y_p1;
   logic              vld_p1, hrefq_p1;

   logic pos_vsync, href_fall, pix_done, active, x_in, y_in, line_chk;
   logic [PW-1:0] pix_word;

   always_comb begin
      pos_vsync = vsync_p0 & ~vsync_p1;
      href_fall = href_p1 & ~href_p0;
      active    = (state == S_ACTIVE);
      pix_done  = href_p0 & (byte_cnt == LAST) & ~pos_vsync;
      x_in      = (x_cnt >= wx0) && (x_cnt <= wx1);
      y_in      = (y_cnt >= wy0) && (y_cnt <= wy1);
      line_chk  = href_fall & ~line_bad & ~pos_vsync;
      pix_word  = pack(acc, data_p0);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT:   if (pos_vsync && (int'(wait_cnt) + 1 >= WAIT_FRAME)) state_nxt = S_ARMED;
         S_ARMED:  if (pos_vsync && cap_en)  state_nxt = S_ACTIVE;
         S_ACTIVE: if (pos_vsync && !cap_en) state_nxt = S_ARMED;
         default:  state_nxt = S_WAIT;
      endcase
   end

   always_ff @(posedge cam_pclk) begin
      if (rst) begin
         state      <= S_WAIT;
         wait_cnt   <= '0;
         vsync_p1   <= 1'b0;
         href_p1    <= 1'b0;
         byte_cnt   <= '0;
         x_cnt      <= '0;
         y_cnt      <= '0;
         ref_cnt    <= '0;
         line_bad   <= 1'b0;
         wx0        <= '0;
         wx1        <= '0;
         wy0        <= '0;
         wy1        <= '0;
         vld_p1     <= 1'b0;
         hrefq_p1   <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         line_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         vsync_p1 <= vsync_p0;
         href_p1  <= href_p0;

         if (state == S_WAIT && pos_vsync && wait_cnt != '1)
            wait_cnt <= wait_cnt + WW'(1);

         if (pos_vsync && cap_en && state != S_WAIT) begin
            wx0 <= win_x0;
            wx1 <= win_x1;
            wy0 <= win_y0;
            wy1 <= win_y1;
         end

         if (pos_vsync || !href_p0 || byte_cnt == LAST) byte_cnt <= '0;
         else                                           byte_cnt <= byte_cnt + BW'(1);

         if (pos_vsync || href_fall) x_cnt <= '0;
         else if (pix_done)          x_cnt <= sat_inc(x_cnt);

         if (pos_vsync)                       y_cnt <= '0;
         else if (line_chk && x_cnt != '0)    y_cnt <= sat_inc(y_cnt);

         if (line_chk && y_cnt == '0 && x_cnt != '0) ref_cnt <= x_cnt;

         // A vsync inside a line poisons the rest of that line for error checks.
         if (pos_vsync && href_p0) line_bad <= 1'b1;
         else if (href_fall)       line_bad <= 1'b0;

         line_err   <= active && line_chk &&
                       (byte_cnt != '0 || (y_cnt != '0 && x_cnt != ref_cnt));
         frame_done <= active && pos_vsync;
         if (active && pos_vsync) frame_cnt <= frame_cnt + 16'd1;

         vld_p1   <= pix_done && active && x_in && y_in;
         hrefq_p1 <= href_p0 && active && y_in && (wx0 <= wx1);
      end
   end

   always_ff @(posedge cam_pclk) begin
      if (href_p0) acc <= pix_word;
      if (pix_done) begin
         data_p1 <= pix_word;
         x_p1    <= x_cnt;
         y_p1    <= y_cnt;
      end
   end

   // ---- stage p2: output registers ----
   always_ff @(posedge cam_pclk) begin
      if (rst) begin
         cmos_frame_vsync <= 1'b0;
         cmos_frame_href  <= 1'b0;
         cmos_frame_valid <= 1'b0;
         cmos_frame_data  <= '0;
         pix_x            <= '0;
         pix_y            <= '0;
      end else begin
         cmos_frame_vsync <= vsync_p1 && active;
         cmos_frame_href  <= hrefq_p1;
         cmos_frame_valid <= vld_p1;
         if (vld_p1) begin
            cmos_frame_data <= data_p1;
            pix_x           <= x_p1;
            pix_y           <= y_p1;
         end
      end
   end

endmodule

// File: doc/cmos_capture_window.md
# cmos_capture_window

Parametrised CMOS camera capture front end for the OV5640 path, sitting between the sensor pins and the frame-buffer writer. It waits a configurable number of frames after configuration, then packs `BPP` sensor bytes into one pixel word. Frame capture starts and stops only on frame boundaries. Only pixels inside a run-time crop window are forwarded. It also provides pixel coordinates, a frame counter, and line-integrity error reporting.

## Interface
- `DATA_W`, 8: sensor bus width.
- `BPP`, 2: sensor bytes per pixel, legal range 1..4.
- `WAIT_FRAME`, 10: number of vsync rising edges ignored after reset.
- `CNT_W`, 12: width of the x/y coordinate counters and window bounds.
- `MSB_FIRST`, 1: if 1, the first byte of a pixel occupies the top bits of the word; if 0, it occupies the bottom bits.

Ports:
- `cam_pclk` in 1: pixel clock, the only clock in the block.
- `rst` in 1: reset, synchronous and active-high.
- `cam_vsync` in 1: sensor frame sync, active-high pulse marking the start of a frame.
- `cam_href` in 1: sensor line valid.
- `cam_data` in `DATA_W`: sensor byte.
- `cap_en` in 1: capture request. Sampled only at frame start.
- `win_x0`, `win_x1`, `win_y0`, `win_y1` in `CNT_W` each: inclusive crop window bounds. Latched at frame start.
- `cmos_frame_vsync` out 1: aligned vsync. Forced to 0 unless the state is ACTIVE.
- `cmos_frame_href` out 1: aligned href, qualified by the y window.
- `cmos_frame_valid` out 1: one-cycle strobe marking a pixel inside the window.
- `cmos_frame_data` out `DATA_W*BPP`: packed pixel word.
- `pix_x`, `pix_y` out `CNT_W` each: coordinates of the pixel currently on `cmos_frame_data`.
- `frame_cnt` out 16: number of completed ACTIVE frames, wraps.
- `frame_done` out 1: one-cycle pulse at the end of each ACTIVE frame.
- `line_err` out 1: one-cycle pulse on a malformed line.

## Operation
- **Input stage.** `cam_vsync`, `cam_href` and `cam_data` are registered once on entry. `pos_vsync` is the rising edge of the registered vsync.
- **FSM states:** WAIT, ARMED, ACTIVE.
  - WAIT: each `pos_vsync` increments a saturating counter. The `pos_vsync` that takes the count to `WAIT_FRAME` moves the FSM to ARMED.
  - ARMED: on `pos_vsync` with `cap_en`=1, move to ACTIVE and latch the window bounds.
  - ACTIVE: on `pos_vsync` with `cap_en`=0, move to ARMED; otherwise re-latch the window bounds and stay in ACTIVE.
  - As a result, frames are always delivered whole, never partial.
- **Byte packing.**
  - A byte counter runs 0..`BPP`-1 while registered href=1 and clears while href=0.
  - A pixel completes when the counter reaches `BPP`-1.
  - Byte order within the word follows `MSB_FIRST`.
  - With `BPP`=1, every byte is a pixel.
- **Coordinates.**
  - `x` clears when href falls and increments after each completed pixel, saturating at 2^`CNT_W`-1.
  - `y` clears on `pos_vsync` and increments when href falls, only if the line contained at least one pixel.
- **Window test.**
  - A pixel is valid only when `win_x0` ≤ x ≤ `win_x1` and `win_y0` ≤ y ≤ `win_y1`, using the latched bounds.
  - If `win_x0` > `win_x1` or `win_y0` > `win_y1`, the window is empty: no `cmos_frame_valid` and no `cmos_frame_href` for that frame.
- **Holding behaviour.** `cmos_frame_data`, `pix_x` and `pix_y` update only on a valid strobe and hold their values otherwise.
- **Frame counting.**
  - On every `pos_vsync` in ACTIVE, except the one that enters ACTIVE, `frame_done` pulses and `frame_cnt` increments.
  - `frame_cnt` wraps from 0xFFFF to 0.
- **Line errors** (ACTIVE only, regardless of the window):
  - `line_err` pulses when href falls with the byte counter ≠ 0, i.e. a trailing partial pixel. The partial pixel is discarded.
  - `line_err` also pulses when the line's pixel count differs from that of line 0 of the same frame.
- **Malformed input.** A `pos_vsync` arriving while href is high clears all counters, discards any partial pixel, and raises no `line_err`.

## Timing
- **Reset.** All outputs are 0 and the FSM is in WAIT. A reset mid-frame aborts the frame; after release the block waits `WAIT_FRAME` frames again.
- **Pixel latency.** If the final byte of a pixel is on `cam_data` at rising edge k, then `cmos_frame_valid`=1, the new `cmos_frame_data` and the new coordinates are visible in the cycle after edge k+2. The strobe lasts exactly one cycle.
- **Sync alignment.** `cmos_frame_vsync` and `cmos_frame_href` are delayed 3 cycles from the pins, which matches the pixel latency.
- **Throughput.** The block sustains one pixel per `BPP` cycles with no stalls. There is no back-pressure.
- **Frame-boundary pulses.** `frame_done` and `line_err` are asserted in the cycle after the edge on which the triggering condition is registered.
- **Coincident events.** If `cap_en` changes on the same cycle as `pos_vsync`, the new value is honoured.

## Test plan
- **Wait-frame gating.** With `WAIT_FRAME`=2 and `cap_en`=1: frames 1–2 produce no output; frame 3 delivers all pixels; `frame_cnt`=1 with a `frame_done` pulse at the vsync of frame 4.
- **Packing and cropping.** `BPP`=2, `MSB_FIRST`=1, 8×4 image with bytes 0x00,0x01,…, window x 2..5, y 1..2: exactly 8 strobes; the first strobe has data 0x1415 with x=2, y=1; `cmos_frame_href` is high on lines 1–2 only.
- **Malformed lines.** A 7-byte line with `BPP`=2 produces a `line_err` pulse and drops the partial pixel. Line 2 shorter than line 0 produces a `line_err` pulse.
- **Mid-frame disable.** Dropping `cap_en` mid-frame lets the current frame complete; the next frame produces no strobes and the FSM is in ARMED. Raising `cap_en` mid-frame has no effect until the next vsync.
- **Empty window.** `win_x0`=6, `win_x1`=3 gives zero strobes, while `frame_cnt` still increments.
- **Reset mid-line.** Asserting `rst` during a line clears all outputs to 0 next cycle, and the block re-waits `WAIT_FRAME` frames.
